// File: rtl/instr_rom_loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
// No timing of its own; pure declarations.
// No backpressure; pure declarations.
//
// Contents: loader state encoding, bus widths, and a byte-address helper.

package instr_rom_loader_pkg;

    localparam int BYTE_W = 8;   // stream byte width
    localparam int WORD_W = 32;  // instruction word width
    localparam int ADDR_W = 32;  // memory byte-address width
    localparam int HDR_W  = 16;  // word-count header width

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_HDR0  = 3'd1,   // waiting for N[7:0]
        LD_HDR1  = 3'd2,   // waiting for N[15:8]
        LD_DATA  = 3'd3,   // collecting the four bytes of a word
        LD_WRITE = 3'd4,   // single-cycle memory write strobe
        LD_DONE  = 3'd5,   // image loaded, core released
        LD_ERR   = 3'd6    // header asked for more words than the memory holds
    } ld_state_e;

    // Byte address of word idx in a word-addressed memory starting at base.
    function automatic logic [ADDR_W-1:0] word_byte_addr(input logic [ADDR_W-1:0] base,
                                                         input logic [ADDR_W-1:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/instr_rom_loader_if.sv
// Byte-stream input and memory write port of the boot loader.
// Latency is set by the modules that drive it; the interface only carries wires.
// Backpressure: rx_ready from the loader stalls the byte source; the memory port has none.
//
// Modports:
//   master - the loader: consumes rx_valid/rx_data, drives rx_ready and the memory write port
//   slave  - the system side: byte source plus instruction memory

interface instr_rom_loader_if;
    import instr_rom_loader_pkg::*;

    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/instr_rom_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words (first byte lands in [7:0]).
// Latency: word updates the cycle after each shift; word_full is combinational on the 4th shift.
// Backpressure: none; the owner only asserts shift_en on an accepted byte.
//
// Ports: clk, rst (sync, active-high), clear (drop partial word), shift_en, byte_in,
//        word (packed result), word_full (this shift completes the word).

module instr_rom_loader_byte_packer
    import instr_rom_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [1:0] lane_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word     <= '0;
            lane_cnt <= '0;
        end else if (shift_en) begin
            // Shift right so that after four bytes the first one sits in lane 0.
            word     <= {byte_in, word[WORD_W-1:BYTE_W]};
            lane_cnt <= lane_cnt + 2'd1;
        end
    end

    assign word_full = shift_en && (lane_cnt == 2'd3);

endmodule

// File: rtl/instr_rom_loader.sv
// Boot loader: header N + 4*N bytes -> N little-endian words written to instruction memory.
// Latency: mem_we is asserted the cycle after the 4th byte of a word; done pulses on entry to DONE.
// Backpressure: rx_ready drops for one cycle per word (the WRITE cycle); the source may stall freely.
//
// Ports: clk, rst (sync, active-high), load_en (arm a load from IDLE/DONE/ERR),
//        bus (master: byte stream in, memory write port out),
//        cpu_hold (core reset, low only in DONE), busy, done (pulse), error (level in ERR).

module instr_rom_loader
    import instr_rom_loader_pkg::*;
#(
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    instr_rom_loader_if.master bus,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               error
);

    // k must reach DEPTH itself (one past the last index), hence the extra bit.
    localparam int          K_W     = $clog2(DEPTH) + 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    ld_state_e         state;
    ld_state_e         state_nxt;
    logic [BYTE_W-1:0] n_lo;
    logic [HDR_W-1:0]  n_words;
    logic [K_W-1:0]    k;
    logic [K_W-1:0]    k_inc;
    logic              done_q;
    logic              xfer;
    logic [HDR_W-1:0]  n_hdr;
    logic              word_full;
    logic [WORD_W-1:0] word;

    assign bus.rx_ready = (state == LD_HDR0) || (state == LD_HDR1) || (state == LD_DATA);
    assign xfer         = bus.rx_valid && bus.rx_ready;
    // Full header as it stands while the high byte is on the bus.
    assign n_hdr        = {bus.rx_data, n_lo};
    assign k_inc        = k + K_W'(1);

    // Partial word is dropped outside DATA, so each word starts from lane 0.
    instr_rom_loader_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state != LD_DATA),
        .shift_en  (xfer && (state == LD_DATA)),
        .byte_in   (bus.rx_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (load_en) begin
                    state_nxt = LD_HDR0;
                end
            end
            LD_HDR0: begin
                if (xfer) begin
                    state_nxt = LD_HDR1;
                end
            end
            LD_HDR1: begin
                if (xfer) begin
                    if (n_hdr == '0) begin
                        state_nxt = LD_DONE;
                    end else if (32'(n_hdr) > DEPTH_U) begin
                        state_nxt = LD_ERR;
                    end else begin
                        state_nxt = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (word_full) begin
                    state_nxt = LD_WRITE;
                end
            end
            LD_WRITE: begin
                if (32'(k_inc) == 32'(n_words)) begin
                    state_nxt = LD_DONE;
                end else begin
                    state_nxt = LD_DATA;
                end
            end
            default: state_nxt = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_lo    <= '0;
            n_words <= '0;
            k       <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_nxt == LD_DONE) && (state != LD_DONE);
            if (state == LD_HDR0 && xfer) begin
                n_lo <= bus.rx_data;
            end
            if (state == LD_HDR1 && xfer) begin
                n_words <= n_hdr;
            end
            // Every new load restarts at word 0; k advances once per write.
            if (state_nxt == LD_HDR0 && state != LD_HDR0) begin
                k <= '0;
            end else if (state == LD_WRITE) begin
                k <= k_inc;
            end
        end
    end

    assign bus.mem_we    = (state == LD_WRITE);
    assign bus.mem_addr  = word_byte_addr(BASE_ADDR, 32'(k));
    assign bus.mem_wdata = word;

    assign cpu_hold = (state != LD_DONE);
    assign busy     = (state == LD_HDR0) || (state == LD_HDR1) ||
                      (state == LD_DATA) || (state == LD_WRITE);
    assign done     = done_q;
    assign error    = (state == LD_ERR);

endmodule
